// File: rtl/div_share_sequencer_if.sv
// rtl/div_share_sequencer_if.sv - request/response bundle between ALU lanes and the shared divider
interface div_share_sequencer_if #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 32
);
   localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ-1:0]            req_ready;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_dividend;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_divisor;
   logic                          flush;
   logic                          resp_valid;
   logic [IDW-1:0]                resp_id;
   logic [DATA_WIDTH-1:0]         resp_quotient;
   logic [DATA_WIDTH-1:0]         resp_remainder;
   logic                          busy;

   modport master (
      output req_valid, req_dividend, req_divisor, flush,
      input  req_ready, resp_valid, resp_id, resp_quotient, resp_remainder, busy
   );

   modport slave (
      input  req_valid, req_dividend, req_divisor, flush,
      output req_ready, resp_valid, resp_id, resp_quotient, resp_remainder, busy
   );
endinterface

// File: rtl/div_share_sequencer.sv
// rtl/div_share_sequencer.sv - round-robin shared radix-2 restoring divider
// One operation in flight; result tagged with the winning lane index.
module div_share_sequencer #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   div_share_sequencer_if.slave  bus
);
   localparam int IDW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNTW = $clog2(DATA_WIDTH + 1);
   localparam logic [CNTW-1:0]    LAST_ITER = CNTW'(DATA_WIDTH - 1);
   localparam logic [NUM_REQ-1:0] ONE_HOT0  = NUM_REQ'(1);
   localparam logic [IDW-1:0]     LAST_ID   = IDW'(NUM_REQ - 1);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

   state_t                r_state;
   state_t                w_next;
   logic [IDW-1:0]        r_rr_ptr;
   logic [IDW-1:0]        r_id;
   logic [DATA_WIDTH-1:0] r_dvd;
   logic [DATA_WIDTH-1:0] r_dvs;
   logic [DATA_WIDTH-1:0] r_rem;
   logic [CNTW-1:0]       r_cnt;
   logic [IDW-1:0]        r_resp_id;
   logic [DATA_WIDTH-1:0] r_resp_q;
   logic [DATA_WIDTH-1:0] r_resp_r;

   logic                  w_grant_valid;
   logic [IDW-1:0]        w_grant_id;
   logic [IDW-1:0]        w_sel;
   logic [DATA_WIDTH-1:0] w_op_dvd;
   logic [DATA_WIDTH-1:0] w_op_dvs;
   logic                  w_accept;
   logic                  w_div_zero;
   logic [DATA_WIDTH:0]   w_rem_sh;
   logic [DATA_WIDTH:0]   w_diff;
   logic                  w_qbit;
   logic [DATA_WIDTH-1:0] w_rem_nx;

   // Walk offsets from the far end so the offset closest to rr_ptr is written last and wins.
   always_comb begin
      w_grant_valid = 1'b0;
      w_grant_id    = '0;
      w_sel         = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         w_sel = IDW'((int'(r_rr_ptr) + k) % NUM_REQ);
         if (bus.req_valid[w_sel]) begin
            w_grant_valid = 1'b1;
            w_grant_id    = w_sel;
         end
      end
   end

   always_comb begin
      w_op_dvd = '0;
      w_op_dvs = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_grant_id == IDW'(i)) begin
            w_op_dvd = bus.req_dividend[i*DATA_WIDTH +: DATA_WIDTH];
            w_op_dvs = bus.req_divisor[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   assign w_accept   = (r_state == S_IDLE) && !bus.flush && w_grant_valid;
   assign w_div_zero = (w_op_dvs == '0);

   // Remainder stays below the divisor, so the extra top bit only carries the borrow.
   assign w_rem_sh = {r_rem, r_dvd[DATA_WIDTH-1]};
   assign w_diff   = w_rem_sh - {1'b0, r_dvs};
   assign w_qbit   = ~w_diff[DATA_WIDTH];
   assign w_rem_nx = w_qbit ? w_diff[DATA_WIDTH-1:0] : w_rem_sh[DATA_WIDTH-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: if (w_accept) w_next = w_div_zero ? S_DONE : S_CALC;
         S_CALC: begin
            if (bus.flush)               w_next = S_IDLE;
            else if (r_cnt == LAST_ITER) w_next = S_DONE;
         end
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rr_ptr  <= '0;
         r_id      <= '0;
         r_dvd     <= '0;
         r_dvs     <= '0;
         r_rem     <= '0;
         r_cnt     <= '0;
         r_resp_id <= '0;
         r_resp_q  <= '0;
         r_resp_r  <= '0;
      end else if (w_accept) begin
         r_rr_ptr <= (w_grant_id == LAST_ID) ? '0 : w_grant_id + 1'b1;
         r_id     <= w_grant_id;
         r_dvd    <= w_op_dvd;
         r_dvs    <= w_op_dvs;
         r_rem    <= '0;
         r_cnt    <= '0;
         if (w_div_zero) begin
            r_resp_id <= w_grant_id;
            r_resp_q  <= '1;
            r_resp_r  <= w_op_dvd;
         end
      end else if (r_state == S_CALC && !bus.flush) begin
         // Dividend register doubles as the quotient shift register.
         r_rem <= w_rem_nx;
         r_dvd <= {r_dvd[DATA_WIDTH-2:0], w_qbit};
         r_cnt <= r_cnt + 1'b1;
         if (r_cnt == LAST_ITER) begin
            r_resp_id <= r_id;
            r_resp_q  <= {r_dvd[DATA_WIDTH-2:0], w_qbit};
            r_resp_r  <= w_rem_nx;
         end
      end
   end

   assign bus.req_ready      = (rst_n && w_accept) ? (ONE_HOT0 << w_grant_id) : '0;
   assign bus.resp_valid     = (r_state == S_DONE) && !bus.flush;
   assign bus.resp_id        = r_resp_id;
   assign bus.resp_quotient  = r_resp_q;
   assign bus.resp_remainder = r_resp_r;
   assign bus.busy           = (r_state != S_IDLE);
endmodule

// File: tb/tb_div_share_sequencer.sv
// tb/tb_div_share_sequencer.sv - directed bench for the shared divider sequencer
module tb_div_share_sequencer;
   logic clk;
   logic rst_n;
   int   passed;
   int   total;

   div_share_sequencer_if #(.NUM_REQ(4), .DATA_WIDTH(32)) bus ();

   div_share_sequencer #(.NUM_REQ(4), .DATA_WIDTH(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic set_lane(input int lane, input logic [31:0] a, input logic [31:0] b);
      bus.req_dividend[lane*32 +: 32] = a;
      bus.req_divisor[lane*32 +: 32]  = b;
   endtask

   // Accept edge happens here; returns the cycle count at which resp_valid is seen.
   task automatic wait_resp(input logic [3:0] keep, output int cyc);
      tick();
      bus.req_valid = bus.req_valid & keep;
      #1;
      cyc = 1;
      while (!bus.resp_valid && cyc < 60) begin
         tick();
         cyc++;
      end
   endtask

   task automatic do_op(input string tag, input int lane, input logic [31:0] a, input logic [31:0] b,
                        input int exp_cyc, input logic [31:0] eq, input logic [31:0] er);
      int cyc;
      set_lane(lane, a, b);
      bus.req_valid = 4'b0001 << lane;
      #1;
      check({tag, " ready"}, 64'(bus.req_ready), 64'(4'b0001 << lane));
      wait_resp(4'b0000, cyc);
      check({tag, " latency"}, 64'(cyc), 64'(exp_cyc));
      check({tag, " id"}, 64'(bus.resp_id), 64'(lane));
      check({tag, " quotient"}, 64'(bus.resp_quotient), 64'(eq));
      check({tag, " remainder"}, 64'(bus.resp_remainder), 64'(er));
      tick();
      check({tag, " busy after"}, 64'(bus.busy), 64'(0));
      check({tag, " hold"}, 64'({bus.resp_valid, bus.resp_quotient}), 64'({1'b0, eq}));
   endtask

   logic [31:0] rr_q [4];
   logic [31:0] rr_r [4];
   int          rr_lane [5];

   initial begin
      int cyc;
      int w;
      logic saw;
      passed = 0;
      total  = 0;
      rr_q    = '{32'd33, 32'd50, 32'd60, 32'd67};
      rr_r    = '{32'd1, 32'd1, 32'd2, 32'd1};
      rr_lane = '{0, 1, 2, 3, 0};
      rst_n            = 1'b0;
      bus.req_valid    = '0;
      bus.req_dividend = '0;
      bus.req_divisor  = '0;
      bus.flush        = 1'b0;
      tick();
      tick();
      check("reset outputs", 64'({bus.busy, bus.resp_valid, bus.req_ready, bus.resp_id}), 64'(0));
      check("reset quotient", 64'(bus.resp_quotient), 64'(0));
      check("reset remainder", 64'(bus.resp_remainder), 64'(0));
      rst_n = 1'b1;
      tick();

      do_op("single", 2, 32'd100, 32'd7, 33, 32'd14, 32'd2);
      do_op("divzero", 0, 32'hDEADBEEF, 32'd0, 1, 32'hFFFFFFFF, 32'hDEADBEEF);
      do_op("max/1", 1, 32'hFFFFFFFF, 32'd1, 33, 32'hFFFFFFFF, 32'd0);
      do_op("5/max", 3, 32'd5, 32'hFFFFFFFF, 33, 32'd0, 32'd5);
      do_op("msb/msb", 0, 32'h80000000, 32'h80000000, 33, 32'd1, 32'd0);
      do_op("pre-rr", 3, 32'd1000, 32'd10, 33, 32'd100, 32'd0);

      for (int i = 0; i < 4; i++) set_lane(i, 32'(100 * (i + 1) + i), 32'(i + 3));
      bus.req_valid = 4'b1111;
      #1;
      for (int g = 0; g < 5; g++) begin
         w = 0;
         while (bus.req_ready == '0 && w < 60) begin
            tick();
            w++;
         end
         check($sformatf("rr%0d gap", g), 64'(w), 64'(0));
         check($sformatf("rr%0d grant", g), 64'(bus.req_ready), 64'(4'b0001 << rr_lane[g]));
         wait_resp(4'b1111, cyc);
         check($sformatf("rr%0d latency", g), 64'(cyc), 64'(33));
         check($sformatf("rr%0d id", g), 64'(bus.resp_id), 64'(rr_lane[g]));
         check($sformatf("rr%0d q", g), 64'({bus.resp_quotient, bus.resp_remainder}),
               64'({rr_q[rr_lane[g]], rr_r[rr_lane[g]]}));
         tick();
      end
      bus.req_valid = '0;
      tick();

      bus.req_valid = 4'b0110;
      #1;
      check("flush grant", 64'(bus.req_ready), 64'(4'b0010));
      tick();
      bus.req_valid = 4'b0100;
      saw = 1'b0;
      for (int c = 1; c < 10; c++) begin
         saw |= bus.resp_valid;
         tick();
      end
      saw |= bus.resp_valid;
      bus.flush = 1'b1;
      #1;
      check("flush cycle", 64'({bus.resp_valid, bus.busy}), 64'(2'b01));
      tick();
      bus.flush = 1'b0;
      #1;
      check("flush busy", 64'(bus.busy), 64'(0));
      check("flush no resp", 64'({saw, bus.resp_valid}), 64'(0));
      check("flush next lane", 64'(bus.req_ready), 64'(4'b0100));
      wait_resp(4'b0000, cyc);
      check("flush next resp", 64'({cyc[7:0], 6'(bus.resp_id), bus.resp_quotient}),
            64'({8'd33, 6'd2, 32'd60}));
      tick();

      bus.req_valid = 4'b1001;
      bus.flush     = 1'b1;
      #1;
      check("idle flush blocks", 64'(bus.req_ready), 64'(0));
      tick();
      check("idle flush busy", 64'(bus.busy), 64'(0));
      bus.flush = 1'b0;
      #1;
      check("idle flush rr kept", 64'(bus.req_ready), 64'(4'b1000));
      wait_resp(4'b0000, cyc);
      check("idle flush resp", 64'({cyc[7:0], 6'(bus.resp_id), bus.resp_quotient}),
            64'({8'd33, 6'd3, 32'd67}));
      tick();

      bus.req_valid = 4'b0100;
      #1;
      check("rst grant", 64'(bus.req_ready), 64'(4'b0100));
      tick();
      bus.req_valid = '0;
      repeat (14) tick();
      rst_n         = 1'b0;
      bus.req_valid = 4'b1010;
      #1;
      check("rst outputs", 64'({bus.busy, bus.resp_valid, bus.req_ready, bus.resp_id}), 64'(0));
      check("rst data", 64'({bus.resp_quotient, bus.resp_remainder}), 64'(0));
      saw = 1'b0;
      for (int c = 0; c < 20; c++) begin
         tick();
         saw |= bus.resp_valid | bus.busy;
      end
      check("rst quiet", 64'(saw), 64'(0));
      rst_n         = 1'b1;
      bus.req_valid = 4'b1111;
      #1;
      check("rst rr_ptr", 64'(bus.req_ready), 64'(4'b0001));
      wait_resp(4'b0000, cyc);
      check("rst resp", 64'({cyc[7:0], 6'(bus.resp_id), bus.resp_quotient, bus.resp_remainder}),
            64'({8'd33, 6'd0, 32'd33, 32'd1}));
      tick();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
